hamming_dec_arbiter: RTL and testbench
======================================

// Module: hamming_dec_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one Hamming [7,4] decoder between NUM_REQ requesters.
//   Accepts one codeword at a time and drives it to the decoder.
//   Waits the decoder latency, then captures data and syndrome.
//   Returns them with the requester id on a valid/ready response port and counts corrected words.
// PARAMETERS
//   NUM_REQ      4   number of requesters (>=2)
//   DEC_LATENCY  1   clk edges from a dec_codeword change until dec_data/dec_syndrome are stable (>=1)
//   CNT_W        16  width of the corrected-word counter
// PORTS
//   clk            in   1            single clock, all logic on posedge
//   rst_n          in   1            asynchronous, active-low reset
//   req_valid      in   NUM_REQ      request pending, one bit per requester
//   req_codeword   in   7*NUM_REQ    codeword of requester i at [7*i+6:7*i]
//   req_ready      out  NUM_REQ      one-hot accept strobe
//   dec_codeword   out  7            registered codeword to shared decoder
//   dec_data       in   4            decoder data output
//   dec_syndrome   in   3            decoder syndrome output
//   rsp_valid      out  1            response available
//   rsp_id         out  $clog2(NUM_REQ)  requester index of response
//   rsp_data       out  4            captured dec_data
//   rsp_corrected  out  1            captured dec_syndrome != 0
//   rsp_ready      in   1            response consumer ready
//   clr_count      in   1            synchronous clear of corr_count
//   corr_count     out  CNT_W        saturating count of responses with rsp_corrected=1
//   busy           out  1            state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE; rr pointer=0; wait counter=0.
//     dec_codeword, rsp_*, corr_count all 0; req_ready=0.
//     An in-flight transaction is dropped with no response.
//   FSM states: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE, any req_valid:
//     Grant the first set bit searching from rr pointer upward with wrap.
//     req_ready[g]=1 combinationally in that cycle (handshake = valid&ready).
//     At that edge: dec_codeword<=req_codeword[g], id<=g, rr<=(g+1)%NUM_REQ, wait counter<=0, state->WAIT.
//   IDLE, no req_valid: dec_codeword holds; rr pointer holds.
//   WAIT:
//     Counter increments each edge.
//     When counter==DEC_LATENCY: capture dec_data, (dec_syndrome!=0) and id into rsp_*; rsp_valid<=1; state->RESP.
//     rsp_valid therefore rises DEC_LATENCY+1 edges after the accept edge.
//   RESP:
//     rsp_* held stable while rsp_valid=1 and rsp_ready=0.
//     On rsp_valid&rsp_ready: rsp_valid<=0, state->IDLE.
//   req_ready=0 in WAIT and RESP. Exactly one transaction in flight.
//   Min accept-to-accept spacing is DEC_LATENCY+3 cycles.
//   corr_count:
//     +1 at the capture edge when syndrome!=0; saturates at all-ones.
//     clr_count loads 0.
//     clr_count coinciding with a corrected capture loads 1.
//   dec_codeword changes only at accept edges, so decoder input is stable through WAIT.
// TESTING
//   1. Reset: rst_n=0 mid-WAIT -> all outputs 0 immediately; after release no rsp_valid, busy=0.
//   2. Single request: req_valid=4'b0100, codeword 7'h5A, bench decoder returns data 4'hB, syndrome 0
//      -> req_ready=4'b0100 for 1 cycle; rsp_valid 2 edges later; rsp_id=2, rsp_data=4'hB, rsp_corrected=0.
//   3. Round-robin: all four req_valid held high
//      -> grants in order 0,1,2,3,0; each rsp_id matches; no requester starved.
//   4. Backpressure: rsp_ready=0 for 5 cycles
//      -> rsp_* stable; req_ready stays 0; completes and returns to IDLE after rsp_ready=1.
//   5. Counter: 3 responses with syndrome 3'b011 -> corr_count=3.
//      clr_count on a corrected capture -> 1; CNT_W=2 with 5 corrections -> saturates at 3.
//   6. DEC_LATENCY=3 -> rsp_valid 4 edges after accept; captured values equal model output at that edge.

Source files
------------

// File: rtl/hamming_dec_arbiter.sv
// Round-robin sequencer that shares one external Hamming [7,4] decoder among NUM_REQ requesters.
// One transaction is in flight at a time: accept, wait out the decoder latency, capture, hold until taken.
module hamming_dec_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DEC_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [7*NUM_REQ-1:0]       req_codeword,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [6:0]                 dec_codeword,
    input  logic [3:0]                 dec_data,
    input  logic [2:0]                 dec_syndrome,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [3:0]                 rsp_data,
    output logic                       rsp_corrected,
    input  logic                       rsp_ready,
    input  logic                       clr_count,
    output logic [CNT_W-1:0]           corr_count,
    output logic                       busy
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int WAIT_W = $clog2(DEC_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   rr_r;
    logic [ID_W-1:0]   id_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic              hi_found_s;
    logic              lo_found_s;
    logic [ID_W-1:0]   hi_idx_s;
    logic [ID_W-1:0]   lo_idx_s;
    logic              grant_found_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [ID_W-1:0]   rr_next_s;
    logic [6:0]        grant_cw_s;
    logic              accept_ok_s;
    logic              capture_s;
    logic              capture_corr_s;

    function automatic logic syndrome_flag(input logic [2:0] syn);
        return (syn != 3'd0);
    endfunction

    // Round-robin pick: lowest requester at or above rr_r, otherwise wrap to the lowest overall.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_found_s = 1'b0;
        lo_idx_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lo_found_s = lo_found_s | req_valid[i];
            lo_idx_s   = req_valid[i] ? ID_W'(i) : lo_idx_s;
            hi_found_s = hi_found_s | (req_valid[i] && (ID_W'(i) >= rr_r));
            hi_idx_s   = (req_valid[i] && (ID_W'(i) >= rr_r)) ? ID_W'(i) : hi_idx_s;
        end
        grant_found_s = lo_found_s;
        grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
        rr_next_s     = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
    end

    // Accept strobe and the selected codeword; strobes stay low in reset and outside IDLE.
    always_comb begin
        accept_ok_s = rst_n && (state_r == ST_IDLE) && grant_found_s;
        req_ready   = '0;
        grant_cw_s  = 7'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept_ok_s && (grant_idx_s == ID_W'(i));
            grant_cw_s   = (grant_idx_s == ID_W'(i)) ? req_codeword[7*i +: 7] : grant_cw_s;
        end
        capture_s      = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_W'(DEC_LATENCY));
        capture_corr_s = capture_s && syndrome_flag(dec_syndrome);
    end

    assign busy = (state_r != ST_IDLE);

    // Transaction sequencer: accept, count decoder latency, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rr_r          <= '0;
            id_r          <= '0;
            wait_cnt_r    <= '0;
            dec_codeword  <= 7'd0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= 4'd0;
            rsp_corrected <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        dec_codeword <= grant_cw_s;
                        id_r         <= grant_idx_s;
                        rr_r         <= rr_next_s;
                        wait_cnt_r   <= '0;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture_s) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= id_r;
                        rsp_data      <= dec_data;
                        rsp_corrected <= syndrome_flag(dec_syndrome);
                        state_r       <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating corrected-word counter; a clear on a corrected capture leaves exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count <= '0;
        end else if (clr_count) begin
            corr_count <= capture_corr_s ? CNT_W'(1) : '0;
        end else if (capture_corr_s && (corr_count != {CNT_W{1'b1}})) begin
            corr_count <= corr_count + CNT_W'(1);
        end else begin
            corr_count <= corr_count;
        end
    end

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Scoreboard bench: two arbiter configurations (latency 1 / 16-bit count, latency 3 / 2-bit count)
// share one stimulus stream; a transaction-level model predicts grants, responses and counts.
module tb_hamming_dec_arbiter;
    localparam int N  = 4;
    localparam int NI = 2;

    typedef struct {
        int inst;
        int id;
        int data;
        int corr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [27:0] req_codeword;
    logic        rsp_ready;
    logic        clr_count;
    logic        stim_done;

    logic [3:0]  req_ready_v [NI];
    logic [6:0]  dec_cw_v    [NI];
    logic [3:0]  dec_data_v  [NI];
    logic [2:0]  dec_syn_v   [NI];
    logic        rsp_valid_v [NI];
    logic [1:0]  rsp_id_v    [NI];
    logic [3:0]  rsp_data_v  [NI];
    logic        rsp_corr_v  [NI];
    logic        busy_v      [NI];
    logic [15:0] corr_a;
    logic [1:0]  corr_b;
    logic [6:0]  pipe_a;
    logic [6:0]  pipe_b [3];

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   m_phase [NI];
    int   m_left  [NI];
    int   m_rr    [NI];
    int   m_cnt   [NI];

    always #5 clk = ~clk;

    // Bench Hamming [7,4] decoder: data in cw[6:3], parity in cw[2:0], single-error correction.
    function automatic logic [6:0] hdec(input logic [6:0] cw);
        logic [2:0] p;
        logic [2:0] s;
        logic [3:0] d;
        p = {cw[6] ^ cw[5] ^ cw[3], cw[6] ^ cw[4] ^ cw[3], cw[5] ^ cw[4] ^ cw[3]};
        s = p ^ cw[2:0];
        d = cw[6:3] ^ {s == 3'd6, s == 3'd5, s == 3'd3, s == 3'd7};
        return {d, s};
    endfunction

    function automatic logic [6:0] henc(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[2] ^ d[1] ^ d[0]};
    endfunction

    always @(posedge clk) begin
        pipe_a    <= dec_cw_v[0];
        pipe_b[0] <= dec_cw_v[1];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign {dec_data_v[0], dec_syn_v[0]} = hdec(pipe_a);
    assign {dec_data_v[1], dec_syn_v[1]} = hdec(pipe_b[2]);

    hamming_dec_arbiter #(.NUM_REQ(4), .DEC_LATENCY(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_codeword(req_codeword),
        .req_ready(req_ready_v[0]), .dec_codeword(dec_cw_v[0]), .dec_data(dec_data_v[0]),
        .dec_syndrome(dec_syn_v[0]), .rsp_valid(rsp_valid_v[0]), .rsp_id(rsp_id_v[0]),
        .rsp_data(rsp_data_v[0]), .rsp_corrected(rsp_corr_v[0]), .rsp_ready(rsp_ready),
        .clr_count(clr_count), .corr_count(corr_a), .busy(busy_v[0])
    );

    hamming_dec_arbiter #(.NUM_REQ(4), .DEC_LATENCY(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_codeword(req_codeword),
        .req_ready(req_ready_v[1]), .dec_codeword(dec_cw_v[1]), .dec_data(dec_data_v[1]),
        .dec_syndrome(dec_syn_v[1]), .rsp_valid(rsp_valid_v[1]), .rsp_id(rsp_id_v[1]),
        .rsp_data(rsp_data_v[1]), .rsp_corrected(rsp_corr_v[1]), .rsp_ready(rsp_ready),
        .clr_count(clr_count), .corr_count(corr_b), .busy(busy_v[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic int dut_cnt(input int i);
        return (i == 0) ? int'(corr_a) : int'(corr_b);
    endfunction

    function automatic int find_grant(input int i);
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr[i] + k) % N]) return (m_rr[i] + k) % N;
        end
        return -1;
    endfunction

    function automatic int find_entry(input int i);
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].inst == i) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s[inst %0d] at %0t: got %0d, required %0d", nm, i, $time, act, exp_v);
        end
    endtask

    task automatic model_reset(input int i);
        int idx;
        m_phase[i] = 0;
        m_left[i]  = 0;
        m_rr[i]    = 0;
        m_cnt[i]   = 0;
        idx = find_entry(i);
        while (idx >= 0) begin
            sb.delete(idx);
            idx = find_entry(i);
        end
    endtask

    task automatic check_reset(input int i);
        chk("rst_req_ready", i, int'(req_ready_v[i]), 0);
        chk("rst_dec_codeword", i, int'(dec_cw_v[i]), 0);
        chk("rst_rsp_valid", i, int'(rsp_valid_v[i]), 0);
        chk("rst_rsp_id", i, int'(rsp_id_v[i]), 0);
        chk("rst_rsp_data", i, int'(rsp_data_v[i]), 0);
        chk("rst_rsp_corrected", i, int'(rsp_corr_v[i]), 0);
        chk("rst_corr_count", i, dut_cnt(i), 0);
        chk("rst_busy", i, int'(busy_v[i]), 0);
        model_reset(i);
    endtask

    task automatic check_cycle(input int i);
        int g;
        int idx;
        g = find_grant(i);
        chk("req_ready", i, int'(req_ready_v[i]), (m_phase[i] == 0 && g >= 0) ? (1 << g) : 0);
        chk("busy", i, int'(busy_v[i]), (m_phase[i] != 0) ? 1 : 0);
        chk("rsp_valid", i, int'(rsp_valid_v[i]), (m_phase[i] == 2) ? 1 : 0);
        chk("corr_count", i, dut_cnt(i), m_cnt[i]);
        if (rsp_valid_v[i]) begin
            idx = find_entry(i);
            if (idx < 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected[inst %0d] at %0t: got rsp_valid=1, required no response", i, $time);
            end else begin
                chk("rsp_id", i, int'(rsp_id_v[i]), sb[idx].id);
                chk("rsp_data", i, int'(rsp_data_v[i]), sb[idx].data);
                chk("rsp_corrected", i, int'(rsp_corr_v[i]), sb[idx].corr);
                if (rsp_ready) sb.delete(idx);
            end
        end
    endtask

    // Predict the effect of the coming clock edge from the inputs that edge will sample.
    task automatic advance(input int i);
        int         g;
        int         idx;
        int         cap_corr;
        exp_t       e;
        logic [6:0] r;
        cap_corr = 0;
        if (m_phase[i] == 1 && m_left[i] == 0) begin
            idx = find_entry(i);
            if (idx >= 0) cap_corr = sb[idx].corr;
        end
        if (clr_count) m_cnt[i] = cap_corr;
        else if (cap_corr != 0 && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        case (m_phase[i])
            0: begin
                g = find_grant(i);
                if (g >= 0) begin
                    r      = hdec(req_codeword[7*g +: 7]);
                    e.inst = i;
                    e.id   = g;
                    e.data = int'(r[6:3]);
                    e.corr = (r[2:0] != 3'd0) ? 1 : 0;
                    sb.push_back(e);
                    m_rr[i]    = (g + 1) % N;
                    m_phase[i] = 1;
                    m_left[i]  = lat_of(i);
                end
            end
            1: begin
                if (m_left[i] == 0) m_phase[i] = 2;
                else m_left[i]--;
            end
            default: begin
                if (rsp_ready) m_phase[i] = 0;
            end
        endcase
    endtask

    initial begin : monitor
        for (int i = 0; i < NI; i++) model_reset(i);
        while (!stim_done) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    check_reset(i);
                end else begin
                    check_cycle(i);
                    advance(i);
                end
            end
        end
        chk("drained", 0, sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic drive(input logic [3:0] v, input logic [27:0] cws, input logic rdy, input logic clr);
        @(negedge clk);
        req_valid    = v;
        req_codeword = cws;
        rsp_ready    = rdy;
        clr_count    = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(4'b0000, 28'd0, 1'b1, 1'b0);
    endtask

    initial begin : stimulus
        logic [27:0] cws;
        stim_done    = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 4'b0000;
        req_codeword = 28'd0;
        rsp_ready    = 1'b1;
        clr_count    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Single request from requester 2 with a clean codeword.
        cws        = 28'd0;
        cws[20:14] = 7'h5A;
        drive(4'b0100, cws, 1'b1, 1'b0);
        idle(8);
        // Everyone requesting: grants must rotate.
        for (int k = 0; k < 40; k++) drive(4'b1111, 28'($urandom), 1'b1, 1'b0);
        idle(8);
        // Response backpressure while other requests wait.
        drive(4'b0001, 28'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) drive(4'b1111, 28'($urandom), 1'b0, 1'b0);
        idle(8);
        // Five single-bit errors giving syndrome 3'b011.
        for (int k = 0; k < 5; k++) begin
            cws       = 28'd0;
            cws[6:0]  = henc(4'($urandom)) ^ 7'b0010000;
            drive(4'b0001, cws, 1'b1, 1'b0);
            idle(7);
        end
        // Clear on the latency-1 instance's corrected capture edge.
        cws      = 28'd0;
        cws[6:0] = henc(4'hA) ^ 7'b0010000;
        drive(4'b0001, cws, 1'b1, 1'b0);
        idle(1);
        drive(4'b0000, 28'd0, 1'b1, 1'b1);
        idle(8);
        // Reset while a transaction is waiting on the decoder.
        drive(4'b0010, 28'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        idle(6);
        for (int k = 0; k < 600; k++) begin
            drive(4'($urandom), 28'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        idle(12);
        stim_done = 1'b1;
    end

endmodule
